// File: rtl/ddr3_mig_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_mig_pkg
// Shared definitions for the MIG-style user-port model: command opcodes,
// engine state encoding, FIFO entry layouts and data-FIFO sizing.
// ----------------------------------------------------------------------------
package ddr3_mig_pkg;

    // Command opcodes on cmd_instr. The PC (precharge) variants behave
    // exactly like their plain counterparts in this model.
    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam logic [2:0] CMD_WRITE_PC = 3'b010;
    localparam logic [2:0] CMD_READ_PC  = 3'b011;
    localparam logic [2:0] CMD_REFRESH  = 3'b100;

    // Write-data and read-data FIFO depth.
    localparam int DATA_FIFO_DEPTH      = 64;
    localparam int DATA_FIFO_DEPTH_BITS = $clog2(DATA_FIFO_DEPTH);

    // FIFO entry widths.
    localparam int CMD_ENTRY_WIDTH = 37;
    localparam int WR_ENTRY_WIDTH  = 36;
    localparam int RD_ENTRY_WIDTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ       = 3'd2,
        ST_READ_DRAIN = 3'd3,
        ST_REFRESH    = 3'd4
    } engine_state_t;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [27:0] word_addr;
    } cmd_entry_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_entry_t;

endpackage

// File: rtl/mig_port_fifo.sv
// ----------------------------------------------------------------------------
// mig_port_fifo
// Generic synchronous first-word-fall-through FIFO with exact registered
// occupancy and full/empty flags.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (flushes contents)
//   push       in   write strobe; ignored while full
//   push_data  in   WIDTH-bit entry to write
//   pop        in   advance head on next edge; ignored while empty
//   head       out  current head entry, valid whenever empty = 0
//   full       out  occupancy == 2^DEPTH_BITS
//   empty      out  occupancy == 0
//   count      out  occupancy 0 .. 2^DEPTH_BITS
// ----------------------------------------------------------------------------
module mig_port_fifo
    import ddr3_mig_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int                    CNT_W      = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS:0]   FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]      mem [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [CNT_W-1:0]      count_d;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage arrays carry no reset; the pointers and count define
    // which entries are live, so a reset only needs to clear those.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            end
            count <= count_d;
            full  <= (count_d == FULL_COUNT);
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/ddr3_mig_port_model.sv
// ----------------------------------------------------------------------------
// ddr3_mig_port_model
// Synthesizable stand-in for a MIG user port: command, write-data and
// read-data FIFOs in front of an on-chip RAM, serviced by a one-beat-per-cycle
// engine (IDLE / WRITE / READ / READ_DRAIN / REFRESH).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_en, cmd_instr, cmd_bl,    command push (opcode, burst length - 1,
//   cmd_word_addr                 word address; upper bits ignored)
//   cmd_empty, cmd_full           command FIFO status
//   wr_en, wr_mask, wr_data       write-data push (mask bit 1 = keep byte)
//   wr_full, wr_empty, wr_count   write FIFO status
//   wr_underrun                   pulse per beat written with no data queued
//   wr_error                      sticky, push while write FIFO full
//   rd_en, rd_data                FWFT read FIFO pop / head
//   rd_full, rd_empty, rd_count   read FIFO status
//   rd_overflow                   pulse per read beat dropped (FIFO full)
//   rd_error                      sticky, pop while read FIFO empty
// ----------------------------------------------------------------------------
module ddr3_mig_port_model
    import ddr3_mig_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int CMD_DEPTH_BITS = 2,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [27:0] cmd_word_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error
);

    localparam int MEM_WORDS = 2**MEM_ADDR_WIDTH;
    localparam int RC_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    // ---------------------------------------------------------------- FIFOs
    cmd_entry_t              cmd_head;
    wr_entry_t               wr_head;
    logic                    cmd_pop;
    logic                    wr_pop;
    logic [CMD_DEPTH_BITS:0] cmd_count_unused;
    logic [27:MEM_ADDR_WIDTH] unused_addr_bits;

    logic [31:0] ram_q;
    logic        land_valid;

    assign unused_addr_bits = cmd_head.word_addr[27:MEM_ADDR_WIDTH];

    mig_port_fifo #(
        .WIDTH      (CMD_ENTRY_WIDTH),
        .DEPTH_BITS (CMD_DEPTH_BITS)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_en),
        .push_data ({cmd_instr, cmd_bl, cmd_word_addr}),
        .pop       (cmd_pop),
        .head      (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count_unused)
    );

    mig_port_fifo #(
        .WIDTH      (WR_ENTRY_WIDTH),
        .DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data ({wr_mask, wr_data}),
        .pop       (wr_pop),
        .head      (wr_head),
        .full      (wr_full),
        .empty     (wr_empty),
        .count     (wr_count)
    );

    // A landing word is offered unconditionally; the FIFO itself drops it
    // when full, and rd_overflow reports that drop.
    mig_port_fifo #(
        .WIDTH      (RD_ENTRY_WIDTH),
        .DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (land_valid),
        .push_data (ram_q),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (rd_full),
        .empty     (rd_empty),
        .count     (rd_count)
    );

    // --------------------------------------------------------------- Engine
    engine_state_t             state, state_d;
    logic [6:0]                beats, beats_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr, ptr_d;
    logic [RC_W-1:0]           rcnt, rcnt_d;

    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        underrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            beats <= '0;
            ptr   <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_d;
            beats <= beats_d;
            ptr   <= ptr_d;
            rcnt  <= rcnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        beats_d    = beats;
        ptr_d      = ptr;
        rcnt_d     = rcnt;
        cmd_pop    = 1'b0;
        wr_pop     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_be     = 4'b1111;
        ram_wdata  = '0;
        underrun_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    beats_d = {1'b0, cmd_head.bl} + 7'd1;
                    ptr_d   = cmd_head.word_addr[MEM_ADDR_WIDTH-1:0];
                    rcnt_d  = RC_W'(REFRESH_CYCLES - 1);
                    case (cmd_head.instr)
                        CMD_WRITE, CMD_WRITE_PC: state_d = ST_WRITE;
                        CMD_READ,  CMD_READ_PC:  state_d = ST_READ;
                        CMD_REFRESH:             state_d = ST_REFRESH;
                        default:                 state_d = ST_IDLE;  // unknown opcode discarded
                    endcase
                end
            end

            ST_WRITE: begin
                ram_we = 1'b1;
                if (!wr_empty) begin
                    wr_pop    = 1'b1;
                    ram_be    = ~wr_head.mask;
                    ram_wdata = wr_head.data;
                end else begin
                    // No data queued: the beat still consumes an address and
                    // writes zeros to all four bytes.
                    underrun_d = 1'b1;
                end
                ptr_d   = ptr + MEM_ADDR_WIDTH'(1);
                beats_d = beats - 7'd1;
                if (beats == 7'd1) begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ: begin
                ram_re  = 1'b1;
                ptr_d   = ptr + MEM_ADDR_WIDTH'(1);
                beats_d = beats - 7'd1;
                if (beats == 7'd1) begin
                    state_d = ST_READ_DRAIN;
                end
            end

            // The last RAM read lands in the read FIFO during this cycle.
            ST_READ_DRAIN: begin
                state_d = ST_IDLE;
            end

            ST_REFRESH: begin
                if (rcnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt - RC_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ RAM
    // Contents survive reset; only the write strobe is gated so a burst in
    // flight when reset arrives writes nothing further.
    logic [31:0] ram [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) begin
                    ram[ptr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_q <= ram[ptr];
        end
    end

    // ---------------------------------------------------- Status / landing
    always_ff @(posedge clk) begin
        if (rst) begin
            land_valid  <= 1'b0;
            wr_underrun <= 1'b0;
            rd_overflow <= 1'b0;
            wr_error    <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            land_valid  <= ram_re;
            wr_underrun <= underrun_d;
            rd_overflow <= land_valid && rd_full;
            wr_error    <= wr_error || (wr_en && wr_full);
            rd_error    <= rd_error || (rd_en && rd_empty);
        end
    end

endmodule

// File: tb/tb_ddr3_mig_port_model.sv
// ----------------------------------------------------------------------------
// tb_ddr3_mig_port_model
// Directed bench: stimulus tasks queue expected read words into a scoreboard;
// a negedge monitor pops and compares each word the bench reads out.
// ----------------------------------------------------------------------------
module tb_ddr3_mig_port_model;
    import ddr3_mig_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [27:0] cmd_word_addr;
    logic        cmd_empty;
    logic        cmd_full;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        wr_empty;
    logic [6:0]  wr_count;
    logic        wr_underrun;
    logic        wr_error;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_full;
    logic        rd_empty;
    logic [6:0]  rd_count;
    logic        rd_overflow;
    logic        rd_error;

    ddr3_mig_port_model #(
        .MEM_ADDR_WIDTH (10),
        .CMD_DEPTH_BITS (2),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_word_addr (cmd_word_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_mask       (wr_mask),
        .wr_data       (wr_data),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_full       (rd_full),
        .rd_empty      (rd_empty),
        .rd_count      (rd_count),
        .rd_overflow   (rd_overflow),
        .rd_error      (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          uf_cnt      = 0;
    int          of_cnt      = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_word;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: a pop happens on the next rising edge whenever rd_en is high
    // and the FIFO is non-empty; the head is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rd_en && !rd_empty) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_unexpected_pop actual=0x%08h required=no_pop", rd_data);
            end else begin
                exp_word = sb.pop_front();
                check("rd_data", rd_data, exp_word);
            end
        end
        if (wr_underrun) uf_cnt++;
        if (rd_overflow) of_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [27:0] addr);
        cmd_instr     = instr;
        cmd_bl        = bl;
        cmd_word_addr = addr;
        cmd_en        = 1'b1;
        tick();
        cmd_en        = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
        wr_data = d;
        wr_mask = m;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop_rd(input logic [31:0] expected);
        sb.push_back(expected);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_rd_count(input string name, input int n, input int budget);
        int i;
        i = 0;
        while (rd_count != 7'(n) && i < budget) begin
            tick();
            i++;
        end
        check(name, 32'(rd_count), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    logic [31:0] t1_words [4];
    logic [31:0] wrap_words [4];
    int          base;

    initial begin
        t1_words   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wrap_words = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3};
        rst = 1'b1;
        cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_word_addr = '0;
        wr_en = 1'b0; wr_mask = '0; wr_data = '0; rd_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset_empties", {29'd0, cmd_empty, wr_empty, rd_empty}, 32'h7);
        check("reset_fulls", {29'd0, cmd_full, wr_full, rd_full}, 32'h0);
        check("reset_counts", {18'd0, wr_count, rd_count}, 32'h0);
        check("reset_flags", {28'd0, wr_underrun, rd_overflow, wr_error, rd_error}, 32'h0);

        // 1: burst write then burst read at 0x10
        for (int i = 0; i < 4; i++) push_wr(t1_words[i], 4'b0000);
        push_cmd(CMD_WRITE_PC, 6'd3, 28'h10);
        push_cmd(CMD_READ_PC, 6'd3, 28'h10);
        wait_rd_count("t1_rd_count", 4, 60);
        repeat (3) tick();
        check("t1_rd_count_stable", 32'(rd_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_rd(t1_words[i]);
        check("t1_no_flags", {uf_cnt[15:0], of_cnt[13:0], wr_error, rd_error}, 32'h0);

        // 2: byte-masked overwrite
        push_wr(32'hAABBCCDD, 4'b0000);
        push_cmd(CMD_WRITE, 6'd0, 28'd5);
        push_wr(32'h11223344, 4'b0101);
        push_cmd(CMD_WRITE, 6'd0, 28'd5);
        push_cmd(CMD_READ, 6'd0, 28'd5);
        wait_rd_count("t2_rd_count", 1, 60);
        pop_rd(32'h11BB33DD);

        // 3: underrun on second beat
        base = uf_cnt;
        push_wr(32'hCAFEF00D, 4'b0000);
        push_cmd(CMD_WRITE, 6'd1, 28'd0);
        repeat (8) tick();
        check("t3_underrun_pulses", 32'(uf_cnt - base), 32'd1);
        push_cmd(CMD_READ, 6'd1, 28'd0);
        wait_rd_count("t3_rd_count", 2, 60);
        pop_rd(32'hCAFEF00D);
        pop_rd(32'h00000000);

        // 4: fill the read FIFO, overflow, drain, pop while empty
        for (int i = 0; i < 64; i++) push_wr(32'h100 + 32'(i), 4'b0000);
        check("t4_wr_full_at_64", {31'd0, wr_full}, 32'd1);
        check("t4_wr_no_error_at_64", {31'd0, wr_error}, 32'd0);
        base = of_cnt;
        push_cmd(CMD_WRITE, 6'd63, 28'h100);
        push_cmd(CMD_READ, 6'd63, 28'h100);
        push_cmd(CMD_READ, 6'd3, 28'h100);
        wait_rd_count("t4_rd_count_64", 64, 400);
        check("t4_rd_full", {31'd0, rd_full}, 32'd1);
        repeat (20) tick();
        check("t4_overflow_pulses", 32'(of_cnt - base), 32'd4);
        check("t4_rd_count_held", 32'(rd_count), 32'd64);
        for (int i = 0; i < 64; i++) pop_rd(32'h100 + 32'(i));
        check("t4_rd_empty_after_drain", {31'd0, rd_empty}, 32'd1);
        check("t4_rd_error_before", {31'd0, rd_error}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("t4_rd_error_set", {31'd0, rd_error}, 32'd1);
        repeat (4) tick();
        check("t4_rd_error_sticky", {31'd0, rd_error}, 32'd1);

        // 5: reset clears sticky flag; RAM survives; command FIFO saturation
        do_reset();
        check("t5_rd_error_cleared", {31'd0, rd_error}, 32'd0);
        push_cmd(CMD_REFRESH, 6'd0, 28'd0);
        for (int i = 0; i < 4; i++) push_cmd(CMD_READ, 6'd0, 28'h10 + 28'(i));
        check("t5_cmd_full_after_4", {31'd0, cmd_full}, 32'd1);
        push_cmd(CMD_READ, 6'd0, 28'd5);
        check("t5_cmd_full_after_5", {31'd0, cmd_full}, 32'd1);
        wait_rd_count("t5_rd_count", 4, 100);
        repeat (10) tick();
        check("t5_only_4_executed", 32'(rd_count), 32'd4);
        for (int i = 0; i < 4; i++) pop_rd(t1_words[i]);

        // 6: address wrap at the top of RAM, then write FIFO overfill
        for (int i = 0; i < 4; i++) push_wr(wrap_words[i], 4'b0000);
        push_cmd(CMD_WRITE, 6'd3, 28'd1022);
        push_cmd(CMD_READ, 6'd3, 28'd1022);
        wait_rd_count("t6_rd_count", 4, 60);
        for (int i = 0; i < 4; i++) pop_rd(wrap_words[i]);
        check("t6_wr_empty", {31'd0, wr_empty}, 32'd1);
        for (int i = 0; i < 64; i++) push_wr(32'h5000 + 32'(i), 4'b0000);
        check("t6_wr_error_at_64", {31'd0, wr_error}, 32'd0);
        push_wr(32'hDEADBEEF, 4'b0000);
        check("t6_wr_full", {31'd0, wr_full}, 32'd1);
        check("t6_wr_count", 32'(wr_count), 32'd64);
        check("t6_wr_error", {31'd0, wr_error}, 32'd1);

        repeat (4) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
